// File: rtl/ln_range_reduce.sv
// ---------------------------------------------------------------------------
// ln_range_reduce
//
// Argument range reduction in front of the ln(x) CORDIC stage. An unsigned
// Q16.16 operand is normalised to x = m * 2^k with m in [1,2), one shift per
// clock. The stage also accumulates k*ln2 in Q16.16 so the downstream combine
// can form ln(x) = ln(m) + k*ln2. A zero operand is flagged through err.
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   st      in   1   start request, level, sampled while idle
//   x_in    in   32  unsigned operand, Q16.16
//   m_out   out  16  mantissa, Q2.14 (0x4000 = 1.0), range 0x4000..0x7FFF
//   k_out   out  6   signed exponent, -16..+15
//   k_ln2   out  32  signed k*LN2_Q16, Q16.16
//   st_out  out  1   one-cycle pulse: m_out/k_out/k_ln2/err valid
//   busy    out  1   operation in progress
//   err     out  1   operand was zero, ln undefined
// ---------------------------------------------------------------------------
module ln_range_reduce #(
    parameter logic [31:0] LN2_Q16 = 32'd45426,
    parameter int          XW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st,
    input  logic [XW-1:0] x_in,
    output logic [15:0]   m_out,
    output logic [5:0]    k_out,
    output logic [31:0]   k_ln2,
    output logic          st_out,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_ZERO = 2'd2
    } state_t;

    // Operand is too large: the leading one sits above bit 16.
    function automatic logic too_big(input logic [31:0] v);
        too_big = (v[31:17] != 15'd0);
    endfunction

    // Operand is too small: bit 16 (the 1.0 position) is clear.
    function automatic logic too_small(input logic [31:0] v);
        too_small = (v[16] == 1'b0);
    endfunction

    state_t      state_q,  state_d;
    logic [31:0] sr_q,     sr_d;
    logic [5:0]  k_q,      k_d;
    logic [31:0] acc_q,    acc_d;
    logic [15:0] m_q,      m_d;
    logic [5:0]  kout_q,   kout_d;
    logic [31:0] kln2_q,   kln2_d;
    logic        stout_q,  stout_d;
    logic        busy_q,   busy_d;
    logic        err_q,    err_d;

    // Next-state and next-output computation for the normalisation FSM.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        k_d     = k_q;
        acc_d   = acc_q;
        m_d     = m_q;
        kout_d  = kout_q;
        kln2_d  = kln2_q;
        stout_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (st) begin
                    sr_d   = x_in[31:0];
                    k_d    = 6'd0;
                    acc_d  = 32'd0;
                    busy_d = 1'b1;
                    if (x_in[31:0] == 32'd0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_NORM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_NORM: begin
                if (too_big(sr_q)) begin
                    // Right shift drops the LSB; no rounding.
                    sr_d  = {1'b0, sr_q[31:1]};
                    k_d   = k_q + 6'd1;
                    acc_d = acc_q + LN2_Q16;
                end else if (too_small(sr_q)) begin
                    sr_d  = {sr_q[30:0], 1'b0};
                    k_d   = k_q - 6'd1;
                    acc_d = acc_q - LN2_Q16;
                end else begin
                    // sr[16] is the 1.0 bit; sr[1:0] fall below Q2.14 and are dropped.
                    m_d     = sr_q[17:2];
                    kout_d  = k_q;
                    kln2_d  = acc_q;
                    err_d   = 1'b0;
                    stout_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_ZERO: begin
                m_d     = 16'd0;
                kout_d  = 6'd0;
                kln2_d  = 32'd0;
                err_d   = 1'b1;
                stout_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= 32'd0;
            k_q     <= 6'd0;
            acc_q   <= 32'd0;
            m_q     <= 16'd0;
            kout_q  <= 6'd0;
            kln2_q  <= 32'd0;
            stout_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            kout_q  <= kout_d;
            kln2_q  <= kln2_d;
            stout_q <= stout_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign m_out  = m_q;
    assign k_out  = kout_q;
    assign k_ln2  = kln2_q;
    assign st_out = stout_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ln_range_reduce.sv
// Directed bench for ln_range_reduce: datapath vectors with hand-computed
// results, then control-path scenarios on x_in = 0x80000000.
module tb_ln_range_reduce;

    logic        clk;
    logic        rst_n;
    logic        st;
    logic [31:0] x_in;
    logic [15:0] m_out;
    logic [5:0]  k_out;
    logic [31:0] k_ln2;
    logic        st_out;
    logic        busy;
    logic        err;

    int total;
    int bad;

    ln_range_reduce dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .st     (st),
        .x_in   (x_in),
        .m_out  (m_out),
        .k_out  (k_out),
        .k_ln2  (k_ln2),
        .st_out (st_out),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one operation, wait for the publish and check everything.
    task automatic op(input string tag, input logic [31:0] x, input int lat,
                      input logic [15:0] m, input logic [5:0] k,
                      input logic [31:0] kl, input logic e);
        int j;
        @(negedge clk);
        x_in = x;
        st   = 1'b1;
        @(negedge clk);
        st   = 1'b0;
        x_in = 32'hDEADBEEF;
        j    = 0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!st_out && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk({tag, "_lat"}, j, lat);
        chk({tag, "_m"}, {16'd0, m_out}, {16'd0, m});
        chk({tag, "_k"}, {26'd0, k_out}, {26'd0, k});
        chk({tag, "_kln2"}, k_ln2, kl);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        @(negedge clk);
        chk({tag, "_pulse1"}, {31'd0, st_out}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int j;
        int pulses;
        int cyc;
        int p1, p2, p3;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        st    = 1'b0;
        x_in  = 32'd0;

        // Reset state
        #12;
        chk("rst_m",    {16'd0, m_out}, 32'd0);
        chk("rst_k",    {26'd0, k_out}, 32'd0);
        chk("rst_kln2", k_ln2, 32'd0);
        chk("rst_flags", {28'd0, st_out, busy, err, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Datapath vectors
        op("one",   32'h00010000,  1, 16'h4000, 6'd0,       32'h00000000, 1'b0);
        op("three", 32'h00030000,  2, 16'h6000, 6'd1,       32'h0000B172, 1'b0);
        op("max",   32'h80000000, 16, 16'h4000, 6'b001111,  32'h000A65AE, 1'b0);
        op("min",   32'h00000001, 17, 16'h4000, 6'b110000,  32'hFFF4E8E0, 1'b0);
        op("half",  32'h00008000,  2, 16'h4000, 6'b111111,  32'hFFFF4E8E, 1'b0);
        op("zero",  32'h00000000,  1, 16'h0000, 6'd0,       32'h00000000, 1'b1);
        op("allon", 32'hFFFFFFFF, 16, 16'h7FFF, 6'b001111,  32'h000A65AE, 1'b0);
        op("mtop",  32'h0001FFFF,  1, 16'h7FFF, 6'd0,       32'h00000000, 1'b0);

        // Second start while busy is ignored
        @(negedge clk);
        x_in = 32'h80000000;
        st   = 1'b1;
        @(negedge clk);
        st   = 1'b0;
        j    = 0;
        while (!st_out && j < 40) begin
            @(negedge clk);
            j++;
            if (j == 4) begin
                st   = 1'b1;
                x_in = 32'h00000001;
            end else begin
                st   = 1'b0;
            end
        end
        st = 1'b0;
        chk("ign_lat", j, 16);
        chk("ign_k", {26'd0, k_out}, {26'd0, 6'b001111});
        chk("ign_kln2", k_ln2, 32'h000A65AE);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st_out) pulses++;
        end
        chk("ign_pulses", pulses, 0);

        // Reset mid-operation
        @(negedge clk);
        x_in = 32'h80000000;
        st   = 1'b1;
        @(negedge clk);
        st   = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_m",    {16'd0, m_out}, 32'd0);
        chk("mrst_k",    {26'd0, k_out}, 32'd0);
        chk("mrst_kln2", k_ln2, 32'd0);
        chk("mrst_flags", {28'd0, st_out, busy, err, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (st_out) pulses++;
        end
        chk("mrst_pulses", pulses, 0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);

        // Start held high: back-to-back publishes
        @(negedge clk);
        x_in = 32'h80000000;
        st   = 1'b1;
        cyc  = 0;
        p1   = -1;
        p2   = -1;
        p3   = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (st_out) begin
                if (p1 < 0) p1 = cyc;
                else if (p2 < 0) p2 = cyc;
                else if (p3 < 0) p3 = cyc;
                else begin end
            end
        end
        st = 1'b0;
        chk("held_first", p1, 17);
        chk("held_gap1", p2 - p1, 17);
        chk("held_gap2", p3 - p2, 17);
        chk("held_k", {26'd0, k_out}, {26'd0, 6'b001111});
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("held_drain", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ln_range_reduce.md
Name: ln_range_reduce

Overview:
- Sequential argument range-reduction stage that sits directly upstream of the ln(x) CORDIC stage.
- Takes a wide unsigned Q16.16 operand and normalises it to x = m * 2^k, with mantissa m in [1,2) in the Q2.14 format the ln stage consumes (0x4000 = 1.0).
- Produces the exponent k and the correction term k*ln2 in Q16.16, so the downstream combine computes ln(x) = ln(m) + k*ln2.
- Keeps the CORDIC hyperbolic vectoring input inside its convergence range for all nonzero inputs.

Parameters:
- LN2_Q16, 45426, ln(2) in Q16.16 (truncated); added or subtracted once per shift.
- XW, 32, input width (Q16.16); fixed at 32 for this revision.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- st  input  1  start request; level, sampled on the rising edge while idle.
- x_in  input  32  unsigned operand, Q16.16.
- m_out  output  16  normalised mantissa, Q2.14, range [0x4000, 0x7FFF]; feeds the ln stage x input.
- k_out  output  6  signed exponent, range -16..+15.
- k_ln2  output  32  signed k*LN2_Q16, Q16.16.
- st_out  output  1  one-cycle pulse: m_out/k_out/k_ln2/err valid; drives the ln stage st.
- busy  output  1  high while an operation is in progress.
- err  output  1  x_in was zero; ln undefined.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; internal shift register, k and accumulator cleared.
- States:
  - IDLE: on a clock edge with st=1, capture x_in into sr[31:0] and clear k and acc to 0. If x_in==0, go to ZERO; else go to NORM. busy goes high at the same edge.
  - NORM, one step per cycle, evaluated in priority order:
    - if sr[31:17]!=0: sr<=sr>>1, k<=k+1, acc<=acc+LN2_Q16.
    - else if sr[16]==0: sr<=sr<<1, k<=k-1, acc<=acc-LN2_Q16.
    - else (sr[16]=1 and sr[31:17]=0): publish m_out<=sr[17:2], k_out<=k, k_ln2<=acc, err<=0, st_out<=1, busy<=0; go to IDLE.
  - ZERO: publish m_out<=0, k_out<=0, k_ln2<=0, err<=1, st_out<=1, busy<=0; go to IDLE.
- Latency: for n shifts, st_out is high n+1 cycles after the start-capture edge. n is at most 16; worst-case latency is 17 cycles.
- st_out is exactly one cycle wide. m_out, k_out, k_ln2 and err hold until the next publish; they are not cleared on a new start.
- st while busy: ignored, with no effect on the operation in flight.
- st high in the cycle st_out is high: accepted (state is already IDLE), giving back-to-back operation.
- st held high continuously: restarts immediately after each publish.
- Truncation: sr[1:0] are discarded on publish; no rounding. A right shift drops the LSB.
- Arithmetic:
  - k is 6-bit two's complement and never overflows (range -16..+15).
  - acc is 32-bit signed; magnitude at most 16*45426, so no overflow.
- x_in is sampled only at the start edge; later changes have no effect.
- Reset mid-operation aborts immediately: no st_out, and outputs return to 0.

Test Plan:
- x_in=0x00010000 (1.0), st pulse -> latency 1: m_out=0x4000, k_out=0, k_ln2=0x00000000, err=0, st_out high 1 cycle.
- x_in=0x00030000 (3.0) -> latency 2: m_out=0x6000, k_out=+1, k_ln2=0x0000B172.
- x_in=0x80000000 -> latency 16: m_out=0x4000, k_out=+15 (6'b001111), k_ln2=0x000A65AE (681390).
- x_in=0x00000001 -> latency 17: m_out=0x4000, k_out=-16 (6'b110000), k_ln2=0xFFF4E8E0.
- x_in=0x00008000 -> latency 2: m_out=0x4000, k_out=-1, k_ln2=0xFFFF4E8E. Then x_in=0 -> latency 1: err=1, m_out=0, k_out=0, st_out pulses.
- Control-path checks, using x_in=0x80000000:
  - A second st at cycle 5 is ignored; a single publish occurs with k_out=+15.
  - rst_n low at cycle 8 -> outputs all 0, busy=0, no st_out.
  - st held high continuously -> back-to-back publishes every 17 cycles.
